// File: rtl/btb_pkg.sv
// Shared types and helpers for the 2-way branch target buffer.
package btb_pkg;

  // Widest PC the entry struct can carry; ways keep only the bits they need.
  localparam int PC_W_MAX = 64;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [PC_W_MAX-1:0] tag;
    logic [PC_W_MAX-1:0] target;
    logic [1:0]          cnt;
  } entry_t;

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int pc_w, input int sets);
    return pc_w - $clog2(sets) - 2;
  endfunction

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == ST) ? ST : cnt + 2'd1;
    end
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/btb_way.sv
// One BTB way: valid/tag/target/counter storage with a lookup port and an update port.
module btb_way
  import btb_pkg::*;
#(
  parameter int SETS = 64,
  parameter int PC_W = 32,
  localparam int INDEX_W = index_w(SETS),
  localparam int TAG_W   = tag_w(PC_W, SETS)
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0]   rd_tag_i,
  output logic               rd_hit_o,
  output logic [PC_W-1:0]    rd_target_o,
  output logic [1:0]         rd_cnt_o,
  input  logic [INDEX_W-1:0] up_idx_i,
  input  logic [TAG_W-1:0]   up_tag_i,
  output logic               up_hit_o,
  output logic               up_valid_o,
  output logic [PC_W-1:0]    up_target_o,
  output logic [1:0]         up_cnt_o,
  input  logic               we_i,
  input  entry_t             wdata_i
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q    [SETS];
  logic [PC_W-1:0]  target_q [SETS];
  logic [1:0]       cnt_q    [SETS];

  always_ff @(posedge clk) begin
    if (rst_i || flush_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[up_idx_i] <= wdata_i.valid;
    end
  end

  // Payload storage is deliberately left unreset; valid gates every use.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[up_idx_i]    <= TAG_W'(wdata_i.tag);
      target_q[up_idx_i] <= PC_W'(wdata_i.target);
      cnt_q[up_idx_i]    <= wdata_i.cnt;
    end
  end

  assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_target_o = target_q[rd_idx_i];
  assign rd_cnt_o    = cnt_q[rd_idx_i];

  assign up_valid_o  = valid_q[up_idx_i];
  assign up_hit_o    = valid_q[up_idx_i] && (tag_q[up_idx_i] == up_tag_i);
  assign up_target_o = target_q[up_idx_i];
  assign up_cnt_o    = cnt_q[up_idx_i];

endmodule

// File: rtl/btb_2way.sv
// 2-way set-associative BTB with per-set pseudo-LRU and 2-bit direction counters.
// Optional lookup/hit/mispredict counters are compiled in with BTB_STATS_EN.
module btb_2way
  import btb_pkg::*;
#(
  parameter int         SETS     = 64,
  parameter int         PC_W     = 32,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic            clk,
  input  logic            rst_i,
  input  logic            flush,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_mispredict
`ifdef BTB_STATS_EN
  ,
  output logic [15:0]     stat_lookups,
  output logic [15:0]     stat_hits,
  output logic [15:0]     stat_mispred
`endif
);

  localparam int INDEX_W = index_w(SETS);
  localparam int TAG_W   = tag_w(PC_W, SETS);

  logic [INDEX_W-1:0] rd_idx, up_idx;
  logic [TAG_W-1:0]   rd_tag, up_tag;
  logic [1:0]         rd_hit, up_hit, up_vld, we;
  logic [PC_W-1:0]    rd_tgt [2];
  logic [PC_W-1:0]    up_tgt [2];
  logic [1:0]         rd_cnt [2];
  logic [1:0]         up_cnt [2];
  entry_t             wdata;

  assign rd_idx = if_pc[INDEX_W+1:2];
  assign rd_tag = if_pc[PC_W-1:INDEX_W+2];
  assign up_idx = upd_pc[INDEX_W+1:2];
  assign up_tag = upd_pc[PC_W-1:INDEX_W+2];

  for (genvar w = 0; w < 2; w++) begin : g_way
    btb_way #(.SETS(SETS), .PC_W(PC_W)) u_way (
      .clk         (clk),
      .rst_i       (rst_i),
      .flush_i     (flush),
      .rd_idx_i    (rd_idx),
      .rd_tag_i    (rd_tag),
      .rd_hit_o    (rd_hit[w]),
      .rd_target_o (rd_tgt[w]),
      .rd_cnt_o    (rd_cnt[w]),
      .up_idx_i    (up_idx),
      .up_tag_i    (up_tag),
      .up_hit_o    (up_hit[w]),
      .up_valid_o  (up_vld[w]),
      .up_target_o (up_tgt[w]),
      .up_cnt_o    (up_cnt[w]),
      .we_i        (we[w]),
      .wdata_i     (wdata)
    );
  end

  // Lookup: way 0 wins a double match, which allocation-on-miss never creates.
  logic [1:0]      sel_cnt;
  logic [PC_W-1:0] sel_tgt;

  always_comb begin
    sel_cnt     = rd_hit[0] ? rd_cnt[0] : rd_cnt[1];
    sel_tgt     = rd_hit[0] ? rd_tgt[0] : rd_tgt[1];
    pred_hit    = if_valid && (|rd_hit);
    pred_taken  = pred_hit && sel_cnt[1];
    pred_target = pred_taken ? sel_tgt : if_pc + PC_W'(4);
  end

  // lru_q[set] names the way to evict next when both ways are valid.
  logic [SETS-1:0] lru_q;
  logic            lru_we, lru_d, way_sel;
  logic [1:0]      old_cnt;
  logic [PC_W-1:0] old_tgt;

  always_comb begin
    we      = 2'b00;
    lru_we  = 1'b0;
    lru_d   = 1'b0;
    way_sel = 1'b0;
    wdata   = '0;
    old_cnt = up_hit[0] ? up_cnt[0] : up_cnt[1];
    old_tgt = up_hit[0] ? up_tgt[0] : up_tgt[1];
    if (upd_valid && !rst_i && !flush) begin
      if (|up_hit) begin
        way_sel      = ~up_hit[0];
        wdata.valid  = 1'b1;
        wdata.tag    = PC_W_MAX'(up_tag);
        wdata.target = PC_W_MAX'(upd_taken ? upd_target : old_tgt);
        wdata.cnt    = cnt_next(old_cnt, upd_taken);
        we           = way_sel ? 2'b10 : 2'b01;
        lru_we       = 1'b1;
        lru_d        = ~way_sel;
      end else if (upd_taken) begin
        if (!up_vld[0]) begin
          way_sel = 1'b0;
        end else if (!up_vld[1]) begin
          way_sel = 1'b1;
        end else begin
          way_sel = lru_q[up_idx];
        end
        wdata.valid  = 1'b1;
        wdata.tag    = PC_W_MAX'(up_tag);
        wdata.target = PC_W_MAX'(upd_target);
        wdata.cnt    = CNT_INIT;
        we           = way_sel ? 2'b10 : 2'b01;
        lru_we       = 1'b1;
        lru_d        = ~way_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i || flush) begin
      lru_q <= '0;
    end else if (lru_we) begin
      lru_q[up_idx] <= lru_d;
    end
  end

  // Byte-offset bits of the update PC carry no information for a 4-byte ISA.
  logic unused_upd;
  assign unused_upd = ^{upd_pc[1:0], upd_mispredict};

`ifdef BTB_STATS_EN
  logic [15:0] lookups_q, hits_q, mispred_q;

  // Statistics survive flush and saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      lookups_q <= '0;
      hits_q    <= '0;
      mispred_q <= '0;
    end else begin
      if (if_valid && (lookups_q != 16'hFFFF)) lookups_q <= lookups_q + 16'd1;
      if (pred_hit && (hits_q != 16'hFFFF))    hits_q    <= hits_q + 16'd1;
      if (upd_valid && upd_mispredict && (mispred_q != 16'hFFFF)) begin
        mispred_q <= mispred_q + 16'd1;
      end
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_hits    = hits_q;
  assign stat_mispred = mispred_q;
`endif

endmodule

// File: tb/tb_btb_2way.sv
// Self-checking bench for btb_2way: recency-list reference model plus directed literal checks.
module tb_btb_2way;

  localparam int SETS = 64;

  logic        clk = 1'b0;
  logic        rst_i, flush, if_valid, upd_valid, upd_taken, upd_mispredict;
  logic [31:0] if_pc, upd_pc, upd_target;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
`ifdef BTB_STATS_EN
  logic [15:0] stat_lookups, stat_hits, stat_mispred;
`endif

  btb_2way #(.SETS(SETS), .PC_W(32), .CNT_INIT(2'b10)) dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .flush          (flush),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups   (stat_lookups),
    .stat_hits      (stat_hits),
    .stat_mispred   (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each set is a recency-ordered list (slot 0 = most recent).
  logic [31:0] m_tag [SETS][2];
  logic [31:0] m_tgt [SETS][2];
  int          m_cnt [SETS][2];
  int          m_n   [SETS];
  int          m_look, m_hit, m_mis;

  function automatic int m_set(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(SETS));
  endfunction

  function automatic logic [31:0] m_tg(input logic [31:0] pc);
    return pc / (32'd4 * 32'(SETS));
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    int s = m_set(pc);
    for (int k = 0; k < m_n[s]; k++) begin
      if (m_tag[s][k] == m_tg(pc)) return k;
    end
    return -1;
  endfunction

  function automatic int m_cnt_of(input logic [31:0] pc);
    int k = m_find(pc);
    return (k < 0) ? -1 : m_cnt[m_set(pc)][k];
  endfunction

  task automatic m_pred(output logic h, output logic t, output logic [31:0] tg);
    int k = m_find(if_pc);
    h  = if_valid && (k >= 0);
    t  = h && (m_cnt[m_set(if_pc)][k] >= 2);
    tg = t ? m_tgt[m_set(if_pc)][k] : if_pc + 32'd4;
  endtask

  always @(posedge clk) begin : model
    logic h, t;
    logic [31:0] tg, t0, g0;
    int s, k, c0;
    m_pred(h, t, tg);
    if (rst_i) begin
      for (int i = 0; i < SETS; i++) m_n[i] = 0;
      m_look = 0; m_hit = 0; m_mis = 0;
    end else begin
      if (if_valid && m_look < 65535) m_look++;
      if (h && m_hit < 65535) m_hit++;
      if (upd_valid && upd_mispredict && m_mis < 65535) m_mis++;
      if (flush) begin
        for (int i = 0; i < SETS; i++) m_n[i] = 0;
      end else if (upd_valid) begin
        s = m_set(upd_pc);
        k = m_find(upd_pc);
        if (k >= 0) begin
          c0 = m_cnt[s][k];
          c0 = upd_taken ? ((c0 + 1 > 3) ? 3 : c0 + 1) : ((c0 - 1 < 0) ? 0 : c0 - 1);
          t0 = upd_taken ? upd_target : m_tgt[s][k];
          g0 = m_tag[s][k];
          if (k == 1) begin
            m_tag[s][1] = m_tag[s][0]; m_tgt[s][1] = m_tgt[s][0]; m_cnt[s][1] = m_cnt[s][0];
          end
          m_tag[s][0] = g0; m_tgt[s][0] = t0; m_cnt[s][0] = c0;
        end else if (upd_taken) begin
          if (m_n[s] >= 1) begin
            m_tag[s][1] = m_tag[s][0]; m_tgt[s][1] = m_tgt[s][0]; m_cnt[s][1] = m_cnt[s][0];
          end
          m_tag[s][0] = m_tg(upd_pc); m_tgt[s][0] = upd_target; m_cnt[s][0] = 2;
          if (m_n[s] < 2) m_n[s]++;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic h, t;
    logic [31:0] tg;
    #3;
    if (chk_en) begin
      m_pred(h, t, tg);
      chk("pred_hit", 32'(pred_hit), 32'(h));
      chk("pred_taken", 32'(pred_taken), 32'(t));
      chk("pred_target", pred_target, tg);
`ifdef BTB_STATS_EN
      chk("stat_lookups", 32'(stat_lookups), 32'(m_look));
      chk("stat_hits", 32'(stat_hits), 32'(m_hit));
      chk("stat_mispred", 32'(stat_mispred), 32'(m_mis));
`endif
    end
  end

  task automatic cyc(input logic r, input logic f, input logic v, input logic [31:0] pc,
                     input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic mis);
    @(negedge clk);
    rst_i = r; flush = f; if_valid = v; if_pc = pc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt; upd_mispredict = mis;
    #3;
  endtask

  task automatic look(input logic [31:0] pc);
    cyc(0, 0, 1, pc, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    cyc(0, 0, 0, 0, 1, pc, t, tgt, 0);
  endtask

  task automatic expect_pred(input string tag, input logic h, input logic t, input logic [31:0] tg);
    chk({tag, "_hit"}, 32'(pred_hit), 32'(h));
    chk({tag, "_taken"}, 32'(pred_taken), 32'(t));
    chk({tag, "_target"}, pred_target, tg);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i = 1; flush = 0; if_valid = 0; if_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_mispredict = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 32'h100, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    expect_pred("idle_after_reset", 0, 0, 32'h104);
`ifdef BTB_STATS_EN
    chk("stats_reset", {16'd0, stat_lookups | stat_hits | stat_mispred}, 32'd0);
`endif

    look(32'h100);
    expect_pred("cold_lookup", 0, 0, 32'h104);

    upd(32'h100, 1, 32'h200);
    look(32'h100);
    expect_pred("trained", 1, 1, 32'h200);
    chk("model_cnt_alloc", 32'(m_cnt_of(32'h100)), 32'd2);

    upd(32'h100, 0, 32'h0);
    upd(32'h100, 0, 32'h0);
    look(32'h100);
    expect_pred("cnt_zero", 1, 0, 32'h104);
    chk("model_cnt_floor", 32'(m_cnt_of(32'h100)), 32'd0);

    for (int i = 0; i < 3; i++) upd(32'h100, 1, 32'h200);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("model_cnt_three", 32'(m_cnt_of(32'h100)), 32'd3);
    upd(32'h100, 1, 32'h200);
    upd(32'h100, 0, 32'h0);
    look(32'h100);
    expect_pred("cnt_saturated", 1, 1, 32'h200);

    upd(32'h200, 1, 32'h2200);
    upd(32'h100, 1, 32'h200);
    upd(32'h300, 1, 32'h3300);
    look(32'h100);
    expect_pred("alias_A_kept", 1, 1, 32'h200);
    look(32'h200);
    expect_pred("alias_B_evicted", 0, 0, 32'h204);
    look(32'h300);
    expect_pred("alias_C_resident", 1, 1, 32'h3300);

    upd(32'h400, 0, 32'h4400);
    look(32'h400);
    expect_pred("nt_miss_no_alloc", 0, 0, 32'h404);

    cyc(0, 0, 1, 32'h1040, 1, 32'h1040, 1, 32'h5000, 0);
    expect_pred("same_cycle_miss", 0, 0, 32'h1044);
    look(32'h1040);
    expect_pred("next_cycle_hit", 1, 1, 32'h5000);

    cyc(0, 0, 1, 32'h100, 1, 32'h2080, 1, 32'h6000, 0);
    expect_pred("indep_lookup", 1, 1, 32'h200);
    look(32'h2080);
    expect_pred("indep_update", 1, 1, 32'h6000);

    look(32'hFFFF_FFFC);
    expect_pred("pc_wrap", 0, 0, 32'h0);

    cyc(0, 0, 0, 32'h100, 0, 0, 0, 0, 0);
    expect_pred("if_valid_low", 0, 0, 32'h104);

    cyc(0, 1, 1, 32'h100, 1, 32'h3000, 1, 32'h7000, 0);
    look(32'h100);
    expect_pred("flush_A", 0, 0, 32'h104);
    look(32'h3000);
    expect_pred("flush_beats_update", 0, 0, 32'h3004);
    look(32'h1040);
    expect_pred("flush_other_set", 0, 0, 32'h1044);

    upd(32'h100, 1, 32'h200);
    look(32'h100);
    expect_pred("retrain", 1, 1, 32'h200);
    cyc(1, 0, 1, 32'h100, 1, 32'h300, 1, 32'h3300, 0);
    look(32'h100);
    expect_pred("reset_mid_train_A", 0, 0, 32'h104);
    look(32'h300);
    expect_pred("reset_mid_train_C", 0, 0, 32'h304);

`ifdef BTB_STATS_EN
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    upd(32'h100, 1, 32'h200);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 32'h100, 1, 32'h200, 1);
    for (int i = 0; i < 70000; i++) look(32'h100);
    chk("stat_lookups_sat", 32'(stat_lookups), 32'hFFFF);
    chk("stat_hits_sat", 32'(stat_hits), 32'hFFFF);
    chk("stat_mispred_3", 32'(stat_mispred), 32'd3);
`endif

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
